// File: rtl/decode_sequencer_pkg.sv
// Shared opcode encodings for the decode sequencer and its datapath neighbours.
// CALL and RET are the newest entries; every other value decodes as an accu load.
package decode_sequencer_pkg;

  localparam int unsigned OpcBits = 5;

  localparam logic [OpcBits-1:0] OpNop  = 5'h00;
  localparam logic [OpcBits-1:0] OpJmp  = 5'h01;
  localparam logic [OpcBits-1:0] OpJez  = 5'h02;
  localparam logic [OpcBits-1:0] OpJnz  = 5'h03;
  localparam logic [OpcBits-1:0] OpJlz  = 5'h04;
  localparam logic [OpcBits-1:0] OpJgz  = 5'h05;
  localparam logic [OpcBits-1:0] OpRst  = 5'h06;
  localparam logic [OpcBits-1:0] OpSt   = 5'h07;
  localparam logic [OpcBits-1:0] OpCall = 5'h08;
  localparam logic [OpcBits-1:0] OpRet  = 5'h09;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are never requested together;
// clr wins over both. dout shows the top entry, zero when empty.
module ret_stack #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth + 1);

  logic [PtrW-1:0]  cnt_q;
  logic [Width-1:0] mem_q [Depth];

  assign full  = (cnt_q == PtrW'(Depth));
  assign empty = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + PtrW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - PtrW'(1);
    end
  end

  // Storage needs no reset: entries are only visible below the count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (push && !full && !clr && cnt_q == PtrW'(i)) begin
        mem_q[i] <= din;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (cnt_q == PtrW'(i + 1)) begin
        dout = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Registered, handshaked instruction decoder: latches one instruction per handshake,
// issues single-cycle control pulses, stalls on stores and handles CALL/RET.
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int unsigned OPC_WIDTH   = 5,
  parameter int unsigned UNDEFINED   = 3,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned REG_BIT_CNT = 3,
  parameter int unsigned CNTR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned COMBINED_DATA = OPC_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [COMBINED_DATA-1:0] data_in,
  input  logic [CNTR_WIDTH-1:0]    pc_in,
  input  logic                     zero_f,
  input  logic                     ls_z_f,
  input  logic                     gr_z_f,
  input  logic                     store_ack,
  output logic [OPC_WIDTH-1:0]     opcode,
  output logic [REG_BIT_CNT-1:0]   reg_sel,
  output logic                     jmp,
  output logic [CNTR_WIDTH-1:0]    jmp_addr,
  output logic                     load,
  output logic                     store,
  output logic                     sys_rst_f,
  output logic                     stack_ovf,
  output logic                     stack_unf
);

  typedef enum logic [1:0] {StFetch, StIssue, StStWait} state_e;

  state_e                  state_q, state_d;
  logic [OPC_WIDTH-1:0]    opc_q;
  logic [CNTR_WIDTH-1:0]   tgt_q, pc_q;
  logic [REG_BIT_CNT-1:0]  rsel_q;
  logic                    zero_q, ls_q, gr_q;
  logic                    ovf_q, unf_q;

  logic                    push, pop, clr, set_ovf, set_unf, take;
  logic [CNTR_WIDTH-1:0]   target, stk_dout;
  logic                    stk_full, stk_empty;

  // Pad bits and the middle of the data field carry nothing for this block.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  ret_stack #(
    .Width (CNTR_WIDTH),
    .Depth (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_f (rst_f),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (pc_q + CNTR_WIDTH'(1)),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= StFetch;
      opc_q   <= '0;
      tgt_q   <= '0;
      pc_q    <= '0;
      rsel_q  <= '0;
      zero_q  <= 1'b0;
      ls_q    <= 1'b0;
      gr_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && instr_valid) begin
        opc_q  <= data_in[COMBINED_DATA-1 -: OPC_WIDTH];
        tgt_q  <= data_in[CNTR_WIDTH-1:0];
        rsel_q <= data_in[DATA_WIDTH-1 -: REG_BIT_CNT];
        pc_q   <= pc_in;
        zero_q <= zero_f;
        ls_q   <= ls_z_f;
        gr_q   <= gr_z_f;
      end
      if (clr) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (set_ovf) ovf_q <= 1'b1;
        if (set_unf) unf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    take        = 1'b0;
    target      = tgt_q;
    load        = 1'b0;
    store       = 1'b0;
    sys_rst_f   = 1'b1;
    push        = 1'b0;
    pop         = 1'b0;
    clr         = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    unique case (state_q)
      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = StIssue;
      end
      StIssue: begin
        state_d = StFetch;
        case (opc_q)
          OPC_WIDTH'(OpNop): ;
          OPC_WIDTH'(OpJmp): take = 1'b1;
          OPC_WIDTH'(OpJez): take = zero_q;
          OPC_WIDTH'(OpJnz): take = !zero_q;
          OPC_WIDTH'(OpJlz): take = ls_q;
          OPC_WIDTH'(OpJgz): take = gr_q;
          OPC_WIDTH'(OpCall): begin
            take    = !stk_full;
            push    = !stk_full;
            set_ovf = stk_full;
          end
          OPC_WIDTH'(OpRet): begin
            take    = !stk_empty;
            pop     = !stk_empty;
            set_unf = stk_empty;
            target  = stk_dout;
          end
          OPC_WIDTH'(OpRst): begin
            sys_rst_f = 1'b0;
            clr       = 1'b1;
          end
          OPC_WIDTH'(OpSt): begin
            store = 1'b1;
            if (!store_ack) state_d = StStWait;
          end
          default: load = 1'b1;
        endcase
      end
      StStWait: begin
        store = 1'b1;
        if (store_ack) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign jmp       = take;
  assign jmp_addr  = take ? target : '0;
  assign opcode    = opc_q;
  assign reg_sel   = rsel_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule
